// File: rtl/bulls_cows_core.sv
// Bulls-and-cows (xAyB) game engine: secret latch, guess scoring and try limit.
// Optional BULLS_COWS_REPEAT_CHECK_EN rejects a guess equal to the previous accepted one.
module bulls_cows_core #(
    parameter int DIGITS    = 4,
    parameter int RADIX     = 10,
    parameter int MAX_TRIES = 10,
    parameter int CW        = $clog2(DIGITS + 1),
    parameter int TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic                  clk18,
    input  logic                  rst,
    input  logic                  key,
    input  logic [4*DIGITS-1:0]   sw,
    output logic [2:0]            state,
    output logic [CW-1:0]         a_cnt,
    output logic [CW-1:0]         b_cnt,
    output logic                  score_valid,
    output logic                  err,
    output logic [TW-1:0]         tries,
    output logic [MAX_TRIES-1:0]  tries_bar
);

    typedef enum logic [2:0] {
        ST_SET   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_GUESS = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    localparam logic [4:0]    RADIX_V = 5'(RADIX);
    localparam logic [CW-1:0] ALL_A   = CW'(DIGITS);
    localparam logic [TW-1:0] MAX_T   = TW'(MAX_TRIES);

    state_t                cur, nxt;
    logic [4*DIGITS-1:0]   secret, secret_n;
    logic [CW-1:0]         a_n, b_n, bulls_v, cows_v;
    logic [TW-1:0]         tries_n;
    logic                  sv_n, err_n, valid, zero, rep;

    function automatic logic entry_ok(input logic [4*DIGITS-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, v[4*i +: 4]} >= RADIX_V) ok = 1'b0;
            for (int j = i + 1; j < DIGITS; j++)
                if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [CW-1:0] count_bulls(input logic [4*DIGITS-1:0] g,
                                                  input logic [4*DIGITS-1:0] s);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DIGITS; i++)
            if (g[4*i +: 4] == s[4*i +: 4]) c = c + 1'b1;
        return c;
    endfunction

    function automatic logic [CW-1:0] count_cows(input logic [4*DIGITS-1:0] g,
                                                 input logic [4*DIGITS-1:0] s);
        logic [CW-1:0] c;
        logic          hit;
        c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hit = 1'b0;
            for (int j = 0; j < DIGITS; j++)
                if (j != i && g[4*i +: 4] == s[4*j +: 4]) hit = 1'b1;
            if (hit) c = c + 1'b1;
        end
        return c;
    endfunction

    function automatic logic [MAX_TRIES-1:0] thermo(input logic [TW-1:0] t);
        logic [MAX_TRIES-1:0] bar;
        for (int k = 0; k < MAX_TRIES; k++) bar[k] = (int'(t) > k);
        return bar;
    endfunction

    assign valid   = entry_ok(sw);
    assign zero    = (sw == '0);
    assign bulls_v = count_bulls(sw, secret);
    assign cows_v  = count_cows(sw, secret);

`ifdef BULLS_COWS_REPEAT_CHECK_EN
    logic [4*DIGITS-1:0] last_guess, last_n;
    assign rep = (sw == last_guess);
`else
    assign rep = 1'b0;
`endif

    always_comb begin
        nxt      = cur;
        secret_n = secret;
        a_n      = a_cnt;
        b_n      = b_cnt;
        tries_n  = tries;
        sv_n     = 1'b0;
        err_n    = 1'b0;
`ifdef BULLS_COWS_REPEAT_CHECK_EN
        last_n   = last_guess;
`endif
        case (cur)
            ST_SET: if (key) begin
                if (valid) begin
                    secret_n = sw;
                    nxt      = ST_WAIT;
                end else err_n = 1'b1;
            end
            ST_WAIT: if (key) begin
                if (zero) begin
                    nxt     = ST_GUESS;
                    tries_n = '0;
                    a_n     = '0;
                    b_n     = '0;
`ifdef BULLS_COWS_REPEAT_CHECK_EN
                    last_n  = '0;
`endif
                end else err_n = 1'b1;
            end
            ST_GUESS: if (key) begin
                if (valid && !rep) begin
                    a_n     = bulls_v;
                    b_n     = cows_v;
                    sv_n    = 1'b1;
                    tries_n = tries + 1'b1;
`ifdef BULLS_COWS_REPEAT_CHECK_EN
                    last_n  = sw;
`endif
                    // A full match wins even on the final try.
                    if (bulls_v == ALL_A)     nxt = ST_WIN;
                    else if (tries_n == MAX_T) nxt = ST_LOSE;
                end else err_n = 1'b1;
            end
            ST_WIN, ST_LOSE: if (key) begin
                if (zero) begin
                    nxt      = ST_SET;
                    secret_n = '0;
                    tries_n  = '0;
                    a_n      = '0;
                    b_n      = '0;
                end else err_n = 1'b1;
            end
            default: begin
                nxt      = ST_SET;
                secret_n = '0;
                tries_n  = '0;
                a_n      = '0;
                b_n      = '0;
`ifdef BULLS_COWS_REPEAT_CHECK_EN
                last_n   = '0;
`endif
            end
        endcase
    end

    // Register stage: every output is taken straight from a flop.
    always_ff @(posedge clk18 or negedge rst) begin
        if (!rst) begin
            cur         <= ST_SET;
            secret      <= '0;
            a_cnt       <= '0;
            b_cnt       <= '0;
            score_valid <= 1'b0;
            err         <= 1'b0;
            tries       <= '0;
            tries_bar   <= '0;
`ifdef BULLS_COWS_REPEAT_CHECK_EN
            last_guess  <= '0;
`endif
        end else begin
            cur         <= nxt;
            secret      <= secret_n;
            a_cnt       <= a_n;
            b_cnt       <= b_n;
            score_valid <= sv_n;
            err         <= err_n;
            tries       <= tries_n;
            tries_bar   <= thermo(tries_n);
`ifdef BULLS_COWS_REPEAT_CHECK_EN
            last_guess  <= last_n;
`endif
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_bulls_cows_core.sv
// Self-checking bench for bulls_cows_core: directed game scenarios then random presses
// against a digit-set reference model.
module tb_bulls_cows_core;

    localparam int DIGITS    = 4;
    localparam int RADIX     = 10;
    localparam int MAX_TRIES = 3;
    localparam int CW        = $clog2(DIGITS + 1);
    localparam int TW        = $clog2(MAX_TRIES + 1);

    logic                 clk18 = 1'b0;
    logic                 rst   = 1'b0;
    logic                 key   = 1'b0;
    logic [4*DIGITS-1:0]  sw    = '0;
    logic [2:0]           state;
    logic [CW-1:0]        a_cnt, b_cnt;
    logic                 score_valid, err;
    logic [TW-1:0]        tries;
    logic [MAX_TRIES-1:0] tries_bar;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_state, m_a, m_b, m_tries;
    bit          m_sv, m_err;
    logic [15:0] m_secret, m_last;

    bulls_cows_core #(.DIGITS(DIGITS), .RADIX(RADIX), .MAX_TRIES(MAX_TRIES)) dut (
        .clk18(clk18), .rst(rst), .key(key), .sw(sw), .state(state),
        .a_cnt(a_cnt), .b_cnt(b_cnt), .score_valid(score_valid), .err(err),
        .tries(tries), .tries_bar(tries_bar)
    );

    always #5 clk18 = ~clk18;

    function automatic int digit(input logic [15:0] v, input int i);
        logic [3:0] d;
        d = v[4*i +: 4];
        return int'(d);
    endfunction

    function automatic bit is_valid(input logic [15:0] v);
        bit seen[16];
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit(v, i) >= RADIX) return 1'b0;
            if (seen[digit(v, i)]) return 1'b0;
            seen[digit(v, i)] = 1'b1;
        end
        return 1'b1;
    endfunction

    function automatic int n_bulls(input logic [15:0] g, input logic [15:0] s);
        int n = 0;
        for (int i = 0; i < DIGITS; i++) if (digit(g, i) == digit(s, i)) n++;
        return n;
    endfunction

    // Digits shared between guess and secret regardless of position.
    function automatic int n_common(input logic [15:0] g, input logic [15:0] s);
        int n = 0;
        for (int i = 0; i < DIGITS; i++)
            for (int j = 0; j < DIGITS; j++)
                if (digit(g, i) == digit(s, j)) n++;
        return n;
    endfunction

    function automatic logic [15:0] rand_code();
        int pool[10];
        int t, r;
        logic [15:0] v;
        for (int i = 0; i < 10; i++) pool[i] = i;
        for (int i = 9; i > 0; i--) begin
            r = $urandom_range(0, i);
            t = pool[i]; pool[i] = pool[r]; pool[r] = t;
        end
        v = '0;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'(pool[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_tries = 0;
        m_sv = 1'b0; m_err = 1'b0; m_secret = '0; m_last = '0;
    endtask

    task automatic model_press(input bit k, input logic [15:0] v);
        bit rep;
        m_sv  = 1'b0;
        m_err = 1'b0;
        if (!k) return;
`ifdef BULLS_COWS_REPEAT_CHECK_EN
        rep = (v == m_last);
`else
        rep = 1'b0;
`endif
        case (m_state)
            0: if (is_valid(v)) begin m_secret = v; m_state = 1; end else m_err = 1'b1;
            1: if (v == 0) begin
                   m_state = 2; m_tries = 0; m_a = 0; m_b = 0; m_last = '0;
               end else m_err = 1'b1;
            2: if (is_valid(v) && !rep) begin
                   m_a = n_bulls(v, m_secret);
                   m_b = n_common(v, m_secret) - m_a;
                   m_sv = 1'b1;
                   m_tries++;
                   m_last = v;
                   if (m_a == DIGITS) m_state = 3;
                   else if (m_tries == MAX_TRIES) m_state = 4;
               end else m_err = 1'b1;
            default: if (v == 0) begin
                   m_state = 0; m_secret = '0; m_tries = 0; m_a = 0; m_b = 0;
               end else m_err = 1'b1;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int bar;
        bar = (1 << m_tries) - 1;
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".a_cnt"}, 32'(a_cnt), 32'(m_a));
        chk({tag, ".b_cnt"}, 32'(b_cnt), 32'(m_b));
        chk({tag, ".score_valid"}, 32'(score_valid), 32'(m_sv));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".tries"}, 32'(tries), 32'(m_tries));
        chk({tag, ".tries_bar"}, 32'(tries_bar), 32'(bar[MAX_TRIES-1:0]));
    endtask

    task automatic press(input string tag, input bit k, input logic [15:0] v);
        key = k;
        sw  = v;
        @(posedge clk18);
        model_press(k, v);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [15:0] v;
        int          c;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk18); #1;
        rst = 1'b1;

        press("set_dup", 1'b1, 16'h1123);
        press("set_ok", 1'b1, 16'h1234);
        press("idle", 1'b0, 16'h1234);
        press("wait_nz", 1'b1, 16'h1234);
        press("wait_zero", 1'b1, 16'h0000);
        press("g1243", 1'b1, 16'h1243);
        press("g5678", 1'b1, 16'h5678);
        press("g12A4", 1'b1, 16'h12A4);
        press("gwin", 1'b1, 16'h1234);
        press("win_nz", 1'b1, 16'h1234);
        press("win_zero", 1'b1, 16'h0000);

        press("l_set", 1'b1, 16'h1234);
        press("l_wait", 1'b1, 16'h0000);
        press("l_g1", 1'b1, 16'h5678);
        press("l_g2", 1'b1, 16'h5679);
        press("l_g3", 1'b1, 16'h5670);
        press("lose_zero", 1'b1, 16'h0000);

        press("w_set", 1'b1, 16'h1234);
        press("w_wait", 1'b1, 16'h0000);
        press("w_g1", 1'b1, 16'h5678);
        press("w_g2", 1'b1, 16'h5679);
        press("w_last", 1'b1, 16'h1234);
        press("w_zero", 1'b1, 16'h0000);

        press("r_set", 1'b1, 16'h1234);
        press("r_wait", 1'b1, 16'h0000);
        press("r_g1", 1'b1, 16'h5678);
        press("r_g2", 1'b1, 16'h5678);

        // Asynchronous reset in the middle of GUESS.
        key = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        @(posedge clk18); #3;
        rst = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            c = $urandom_range(0, 5);
            case (c)
                0:       v = 16'h0000;
                1:       v = m_secret;
                2, 3:    v = rand_code();
                4:       v = 16'($urandom);
                default: v = sw;
            endcase
            press("rand", ($urandom_range(0, 3) != 0), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
